// File: rtl/gbt_lpbk_checker_if.sv
// Receive-stream and status bundle between the GBT loopback test harness and the pattern checker.
// The master drives the qualified receive stream and controls; the slave reports lock state, counters and captures.
interface gbt_lpbk_checker_if #(
   parameter int CNT_W = 32
);
   logic             ena;
   logic             clr;
   logic [15:0]      din;
   logic             dvld;
   logic             locked;
   logic [1:0]       state;
   logic             err_pulse;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [15:0]      bad_data;
   logic [15:0]      exp_data;

   modport master (
      output ena, clr, din, dvld,
      input  locked, state, err_pulse, word_cnt, err_cnt, bad_data, exp_data
   );

   modport slave (
      input  ena, clr, din, dvld,
      output locked, state, err_pulse, word_cnt, err_cnt, bad_data, exp_data
   );
endinterface

// File: rtl/gbt_lpbk_checker.sv
// Incrementing-counter pattern checker for the GBTx loopback path.
// It seeks a run of in-sequence words, locks, and then counts words and mismatches and captures the last bad word.
module gbt_lpbk_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 8,
   parameter int CNT_W    = 32
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   gbt_lpbk_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SEEK   = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);
   localparam logic [7:0]       LOSS_C  = 8'(LOSS_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [15:0]      r_exp;
   logic [7:0]       r_run;
   logic [7:0]       r_miss;
   logic             r_errPulse;
   logic [CNT_W-1:0] r_wordCnt;
   logic [CNT_W-1:0] r_errCnt;
   logic [15:0]      r_badData;
   logic [15:0]      r_expData;

   logic [15:0]      w_dinInc;
   logic [15:0]      w_expInc;
   logic [7:0]       w_runInc;
   logic [7:0]       w_missInc;
   logic             w_match;

   assign w_dinInc  = bus.din + 16'd1;
   assign w_expInc  = r_exp + 16'd1;
   assign w_runInc  = r_run + 8'd1;
   assign w_missInc = r_miss + 8'd1;
   assign w_match   = (bus.din == r_exp);

   // CLR is applied last so it overrides any same-cycle increment or capture, but never the error pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_exp      <= 16'd0;
         r_run      <= 8'd0;
         r_miss     <= 8'd0;
         r_errPulse <= 1'b0;
         r_wordCnt  <= '0;
         r_errCnt   <= '0;
         r_badData  <= 16'd0;
         r_expData  <= 16'd0;
      end else begin
         r_errPulse <= 1'b0;
         if (!bus.ena) begin
            r_state <= ST_IDLE;
            r_run   <= 8'd0;
            r_miss  <= 8'd0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_SEEK;
                  r_run   <= 8'd0;
               end
               ST_SEEK: begin
                  if (bus.dvld) begin
                     r_exp <= w_dinInc;
                     if (r_run == 8'd0 || !w_match) begin
                        r_run <= 8'd1;
                     end else begin
                        r_run <= w_runInc;
                        if (w_runInc == LOCK_C) begin
                           r_state <= ST_LOCKED;
                           r_miss  <= 8'd0;
                        end
                     end
                  end
               end
               ST_LOCKED: begin
                  if (bus.dvld) begin
                     r_exp <= w_expInc;
                     if (r_wordCnt != '1) r_wordCnt <= r_wordCnt + CNT_ONE;
                     if (w_match) begin
                        r_miss <= 8'd0;
                     end else begin
                        r_errPulse <= 1'b1;
                        r_badData  <= bus.din;
                        r_expData  <= r_exp;
                        if (r_errCnt != '1) r_errCnt <= r_errCnt + CNT_ONE;
                        r_miss <= w_missInc;
                        if (w_missInc == LOSS_C) begin
                           r_state <= ST_SEEK;
                           r_run   <= 8'd0;
                        end
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
         if (bus.clr) begin
            r_wordCnt <= '0;
            r_errCnt  <= '0;
            r_badData <= 16'd0;
            r_expData <= 16'd0;
         end
      end
   end

   assign bus.locked    = (r_state == ST_LOCKED);
   assign bus.state     = r_state;
   assign bus.err_pulse = r_errPulse;
   assign bus.word_cnt  = r_wordCnt;
   assign bus.err_cnt   = r_errCnt;
   assign bus.bad_data  = r_badData;
   assign bus.exp_data  = r_expData;

endmodule

// File: tb/tb_gbt_lpbk_checker.sv
// Directed bench for gbt_lpbk_checker: lock, wrap, single error, loss/relock, gapped seeding, CLR, ENA, saturation and reset.
// Counters are 8 bits wide here so that saturation is reachable in a few hundred cycles.
module tb_gbt_lpbk_checker;

   localparam int CNT_W = 8;

   logic i_clk;
   logic i_rst_n;
   int   checks;
   int   errors;

   gbt_lpbk_checker_if #(.CNT_W(CNT_W)) bus ();

   gbt_lpbk_checker #(
      .LOCK_CNT (4),
      .LOSS_CNT (8),
      .CNT_W    (CNT_W)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // One clock of stimulus: inputs change just after an edge and outputs are read 1 ns after the next edge.
   task automatic applyStimulus(input logic e, input logic c, input logic v, input logic [15:0] d);
      bus.ena  = e;
      bus.clr  = c;
      bus.dvld = v;
      bus.din  = d;
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_state"},    32'(bus.state),     32'h0);
      checkOutput({tag, "_locked"},   32'(bus.locked),    32'h0);
      checkOutput({tag, "_pulse"},    32'(bus.err_pulse), 32'h0);
      checkOutput({tag, "_wordcnt"},  32'(bus.word_cnt),  32'h0);
      checkOutput({tag, "_errcnt"},   32'(bus.err_cnt),   32'h0);
      checkOutput({tag, "_baddata"},  32'(bus.bad_data),  32'h0);
      checkOutput({tag, "_expdata"},  32'(bus.exp_data),  32'h0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      i_rst_n  = 1'b0;
      bus.ena  = 1'b0;
      bus.clr  = 1'b0;
      bus.dvld = 1'b0;
      bus.din  = 16'h0;
      #12;
      checkAllZero("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // Lock on 0x0100..0x0103, then one checked match
      applyStimulus(1, 0, 0, 16'h0000);
      checkOutput("seek_state", 32'(bus.state), 32'h1);
      applyStimulus(1, 0, 1, 16'h0100);
      applyStimulus(1, 0, 1, 16'h0101);
      applyStimulus(1, 0, 1, 16'h0102);
      checkOutput("lock_not_yet", 32'(bus.locked), 32'h0);
      applyStimulus(1, 0, 1, 16'h0103);
      checkOutput("lock_locked", 32'(bus.locked), 32'h1);
      checkOutput("lock_state", 32'(bus.state), 32'h2);
      checkOutput("lock_wordcnt0", 32'(bus.word_cnt), 32'h0);
      applyStimulus(1, 0, 1, 16'h0104);
      checkOutput("lock_wordcnt1", 32'(bus.word_cnt), 32'h1);
      checkOutput("lock_errcnt", 32'(bus.err_cnt), 32'h0);
      checkOutput("lock_pulse", 32'(bus.err_pulse), 32'h0);

      // Dropping ENA wins over the same-cycle word, which is not counted
      applyStimulus(0, 0, 1, 16'h0105);
      checkOutput("ena_state", 32'(bus.state), 32'h0);
      checkOutput("ena_wordhold", 32'(bus.word_cnt), 32'h1);

      // Wrap FFFF -> 0000 must match
      applyStimulus(1, 1, 0, 16'h0000);
      checkOutput("clr_wordcnt", 32'(bus.word_cnt), 32'h0);
      checkOutput("wrap_seek", 32'(bus.state), 32'h1);
      applyStimulus(1, 0, 1, 16'hFFFC);
      applyStimulus(1, 0, 1, 16'hFFFD);
      applyStimulus(1, 0, 1, 16'hFFFE);
      applyStimulus(1, 0, 1, 16'hFFFF);
      checkOutput("wrap_locked", 32'(bus.locked), 32'h1);
      applyStimulus(1, 0, 1, 16'h0000);
      checkOutput("wrap_pulse0", 32'(bus.err_pulse), 32'h0);
      applyStimulus(1, 0, 1, 16'h0001);
      checkOutput("wrap_pulse1", 32'(bus.err_pulse), 32'h0);
      checkOutput("wrap_wordcnt", 32'(bus.word_cnt), 32'h2);
      checkOutput("wrap_errcnt", 32'(bus.err_cnt), 32'h0);

      // Single error with exp=0x2005
      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(1, 0, 0, 16'h0000);
      applyStimulus(1, 0, 1, 16'h2001);
      applyStimulus(1, 0, 1, 16'h2002);
      applyStimulus(1, 0, 1, 16'h2003);
      applyStimulus(1, 0, 1, 16'h2004);
      checkOutput("single_locked", 32'(bus.locked), 32'h1);
      applyStimulus(1, 0, 1, 16'h2A05);
      checkOutput("single_pulse", 32'(bus.err_pulse), 32'h1);
      checkOutput("single_errcnt", 32'(bus.err_cnt), 32'h1);
      checkOutput("single_bad", 32'(bus.bad_data), 32'h2A05);
      checkOutput("single_exp", 32'(bus.exp_data), 32'h2005);
      checkOutput("single_wordcnt", 32'(bus.word_cnt), 32'h3);
      applyStimulus(1, 0, 1, 16'h2006);
      checkOutput("single_match_pulse", 32'(bus.err_pulse), 32'h0);
      checkOutput("single_match_errcnt", 32'(bus.err_cnt), 32'h1);
      checkOutput("single_still_locked", 32'(bus.locked), 32'h1);
      checkOutput("single_wordcnt2", 32'(bus.word_cnt), 32'h4);

      // Loss after 8 consecutive mismatches (exp runs 0x2007..0x200E), then relock
      applyStimulus(1, 1, 0, 16'h0000);
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 1, 16'h0000);
      checkOutput("loss_7_locked", 32'(bus.locked), 32'h1);
      checkOutput("loss_7_errcnt", 32'(bus.err_cnt), 32'h7);
      applyStimulus(1, 0, 1, 16'h0000);
      checkOutput("loss_errcnt", 32'(bus.err_cnt), 32'h8);
      checkOutput("loss_wordcnt", 32'(bus.word_cnt), 32'h8);
      checkOutput("loss_locked", 32'(bus.locked), 32'h0);
      checkOutput("loss_state", 32'(bus.state), 32'h1);
      checkOutput("loss_expdata", 32'(bus.exp_data), 32'h200E);
      applyStimulus(1, 0, 1, 16'h5000);
      applyStimulus(1, 0, 1, 16'h5001);
      applyStimulus(1, 0, 1, 16'h5002);
      checkOutput("relock_not_yet", 32'(bus.locked), 32'h0);
      applyStimulus(1, 0, 1, 16'h5003);
      checkOutput("relock_locked", 32'(bus.locked), 32'h1);
      applyStimulus(1, 0, 1, 16'h5004);
      checkOutput("relock_pulse", 32'(bus.err_pulse), 32'h0);
      checkOutput("relock_errcnt", 32'(bus.err_cnt), 32'h8);

      // Gapped seeding: 0x30 breaks the 0x10/0x11 run, lock only after 0x33
      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(1, 0, 0, 16'h0000);
      begin
         logic [15:0] seq [6];
         seq = '{16'h0010, 16'h0011, 16'h0030, 16'h0031, 16'h0032, 16'h0033};
         for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 1, seq[i]);
            if (i == 4) checkOutput("gap_not_yet", 32'(bus.locked), 32'h0);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) applyStimulus(1, 0, 0, 16'hDEAD);
         end
      end
      checkOutput("gap_locked", 32'(bus.locked), 32'h1);
      applyStimulus(1, 1, 0, 16'h0000);
      applyStimulus(1, 0, 1, 16'h0034);
      checkOutput("gap_exp34_pulse", 32'(bus.err_pulse), 32'h0);
      checkOutput("gap_exp34_wordcnt", 32'(bus.word_cnt), 32'h1);
      checkOutput("gap_exp34_errcnt", 32'(bus.err_cnt), 32'h0);

      // CLR in the same cycle as a mismatch (exp 0x35 then 0x36)
      applyStimulus(1, 0, 1, 16'h0099);
      checkOutput("clrerr_pre_errcnt", 32'(bus.err_cnt), 32'h1);
      applyStimulus(1, 1, 1, 16'h0077);
      checkOutput("clrerr_errcnt", 32'(bus.err_cnt), 32'h0);
      checkOutput("clrerr_pulse", 32'(bus.err_pulse), 32'h1);
      checkOutput("clrerr_wordcnt", 32'(bus.word_cnt), 32'h0);
      checkOutput("clrerr_bad", 32'(bus.bad_data), 32'h0);
      checkOutput("clrerr_locked", 32'(bus.locked), 32'h1);

      // Word counter saturates at all-ones (exp continues from 0x37)
      applyStimulus(1, 1, 0, 16'h0000);
      for (int i = 0; i < 260; i++) applyStimulus(1, 0, 1, 16'(16'h0037 + i));
      checkOutput("sat_wordcnt", 32'(bus.word_cnt), 32'hFF);
      checkOutput("sat_errcnt", 32'(bus.err_cnt), 32'h0);
      checkOutput("sat_locked", 32'(bus.locked), 32'h1);

      // Asynchronous reset mid-stream
      bus.din  = 16'h0137;
      #2;
      i_rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
